br_resolve_ctrl: RTL
====================

Name: br_resolve_ctrl

Overview:
- Sequencer for the branch-condition unit in the execute stage.
- Accepts one branch at a time from issue over a valid/ready handshake and registers its operands.
- Evaluates the condition with an internal brCond instance and computes the target.
- On taken branches, drives a redirect handshake to fetch plus a one-cycle flush to decode. Then reports the resolution to the commit side.

Parameters:
- DW, `WIDTH: operand, PC and immediate width.
- OPW, `BR_OP_LEN: branch-type code width.

Ports:
- clk  in  1: clock.
- rst  in  1: synchronous active-high reset.
- kill  in  1: synchronous abort from the exception path.
- in_valid  in  1: branch request valid.
- in_ready  out  1: block can accept a request.
- in_pc  in  DW: PC of the branch.
- in_imm  in  DW: signed word offset.
- in_rs1  in  DW: operand 1.
- in_rs2  in  DW: operand 2.
- in_type  in  OPW: branch type code.
- redir_valid  out  1: redirect request to fetch.
- redir_ready  in  1: fetch accepts the redirect.
- redir_pc  out  DW: redirect target.
- flush  out  1: one-cycle pulse that squashes decode.
- res_valid  out  1: resolution available.
- res_ready  in  1: commit side accepts the resolution.
- res_taken  out  1: branch was taken.
- res_target  out  DW: target PC (taken or fall-through).
- res_illegal  out  1: in_type was not a legal branch code.

Behaviour:
- Reset: state=IDLE; all outputs 0 except in_ready=1. Captured registers cleared to 0.
- FSM states: IDLE, EVAL, REDIR, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready&~kill, capture pc/imm/rs1/rs2/type, then go to EVAL.
  - in_ready is 0 in all other states.
- EVAL (exactly 1 cycle):
  - brCond evaluates the captured rs1/rs2/type.
  - Taken target = pc + (imm<<2), truncated to DW (wraps mod 2^DW). Fall-through = pc + 4, also wrapping.
  - Register taken, the selected target, and illegal.
  - If taken, go to REDIR; otherwise go to DONE.
- Illegal type:
  - A type other than `BR_EQ/`BR_NE/`BR_LZ/`BR_GZ/`BR_GE/`BR_LE is treated as not taken.
  - res_illegal=1; target = fall-through.
  - No redirect is issued.
- REDIR:
  - redir_valid=1 with redir_pc=target, held stable until redir_ready.
  - On the handshake cycle: flush=1 (that cycle only), then go to DONE.
  - flush never asserts outside a redirect handshake.
- DONE:
  - res_valid=1 with res_taken/res_target/res_illegal, held stable until res_ready.
  - On the handshake, go to IDLE.
- Latency, counted from the capture edge (cycle 0):
  - Not taken: res_valid at cycle 2.
  - Taken: redir_valid at cycle 2; with redir_ready=1, flush at cycle 2 and res_valid at cycle 3.
  - Back-to-back throughput: one branch per 3 cycles (not taken) or 4 cycles (taken, zero backpressure).
- kill:
  - In any state, go to IDLE next cycle.
  - In the kill cycle, the redirect/result handshakes are ignored and flush is forced 0.
  - A request presented in IDLE during kill is not captured.
  - kill has priority over every other event.
- rst mid-operation: same as reset, next cycle; all outputs return to reset values.
- Outputs redir_pc/res_* are registered (no combinational path from inputs).

Optional Feature:
BR_RESOLVE_STATS_EN
- Defined: adds outputs stat_total (32) and stat_taken (32), cleared by rst.
  - stat_total increments on each res handshake.
  - stat_taken increments on each res handshake with res_taken=1.
  - Both wrap at 2^32 and are not affected by kill.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- BR_EQ, rs1=rs2=5, pc=0x100, imm=3, redir_ready=res_ready=1:
  - redir_valid cycle 2 with redir_pc=0x10C, flush pulse cycle 2.
  - res_valid cycle 3 with taken=1, target=0x10C.
- BR_LZ, rs1=0 (then rs1=0x80000000), pc=0x200, imm=4:
  - First: not taken, res_target=0x204, no flush.
  - Second: taken, target=0x210.
- Backpressure: BR_NE, rs1=1, rs2=2, redir_ready=0 for 5 cycles:
  - redir_valid and redir_pc stay stable, flush stays 0, in_ready stays 0.
  - flush fires on the ready cycle.
- Wrap: pc=0xFFFFFFFC, BR_GE, rs1=0, imm=1 → target=0x00000000. Not-taken variant (BR_GZ, rs1=0) → target=0x00000000.
- Illegal in_type, then kill asserted while in REDIR for a legal taken branch:
  - Illegal: res_illegal=1, taken=0, no redirect.
  - kill case: next cycle IDLE, in_ready=1, no flush pulse, no res_valid.
- Stats (macro on): 4 branches, 3 taken, then rst → stat_total=4, stat_taken=3, then 0/0 after rst.

Source files
------------

// File: rtl/br_resolve_ctrl.sv
// br_resolve_ctrl: execute-stage branch resolution sequencer.
// Takes one branch from issue, evaluates it with br_cond, redirects fetch
// and flushes decode when the branch is taken, then reports the outcome
// to commit.
// Optional build macro: BR_RESOLVE_STATS_EN adds stat_total/stat_taken
// counters of resolved and taken branches.

`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef BR_OP_LEN
`define BR_OP_LEN 3
`endif
`ifndef BR_EQ
`define BR_EQ 0
`endif
`ifndef BR_NE
`define BR_NE 1
`endif
`ifndef BR_LZ
`define BR_LZ 2
`endif
`ifndef BR_GZ
`define BR_GZ 3
`endif
`ifndef BR_GE
`define BR_GE 4
`endif
`ifndef BR_LE
`define BR_LE 5
`endif

// Branch condition evaluator. Single-operand tests treat rs1 as signed.
// Any code outside the six legal branch types is reported as illegal and
// evaluates to not taken.
module br_cond #(
   parameter int DW  = `WIDTH,
   parameter int OPW = `BR_OP_LEN
) (
   input  logic [DW-1:0]  rs1,
   input  logic [DW-1:0]  rs2,
   input  logic [OPW-1:0] typ,
   output logic           taken,
   output logic           illegal
);

   logic w_eq;
   logic w_neg;
   logic w_zero;

   assign w_eq   = (rs1 == rs2);
   assign w_neg  = rs1[DW-1];
   assign w_zero = (rs1 == '0);

   // Decode the branch type into a taken decision and an illegal flag.
   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (typ)
         OPW'(`BR_EQ): taken = w_eq;
         OPW'(`BR_NE): taken = ~w_eq;
         OPW'(`BR_LZ): taken = w_neg;
         OPW'(`BR_GZ): taken = ~w_neg & ~w_zero;
         OPW'(`BR_GE): taken = ~w_neg;
         OPW'(`BR_LE): taken = w_neg | w_zero;
         default:      illegal = 1'b1;
      endcase
   end

endmodule

// Sequencer FSM
// state | meaning
// IDLE  | waiting for a branch from issue, in_ready=1
// EVAL  | condition and target evaluated, result registered
// REDIR | taken branch, redirect to fetch pending; flush on handshake
// DONE  | resolution presented to commit until accepted
module br_resolve_ctrl #(
   parameter int DW  = `WIDTH,
   parameter int OPW = `BR_OP_LEN
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           kill,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [DW-1:0]  in_pc,
   input  logic [DW-1:0]  in_imm,
   input  logic [DW-1:0]  in_rs1,
   input  logic [DW-1:0]  in_rs2,
   input  logic [OPW-1:0] in_type,
   output logic           redir_valid,
   input  logic           redir_ready,
   output logic [DW-1:0]  redir_pc,
   output logic           flush,
   output logic           res_valid,
   input  logic           res_ready,
   output logic           res_taken,
   output logic [DW-1:0]  res_target,
   output logic           res_illegal
`ifdef BR_RESOLVE_STATS_EN
   ,
   output logic [31:0]    stat_total,
   output logic [31:0]    stat_taken
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_EVAL  = 2'd1;
   localparam logic [1:0] S_REDIR = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]     r_state;
   logic [1:0]     w_state_nxt;

   logic [DW-1:0]  r_pc;
   logic [DW-1:0]  r_imm;
   logic [DW-1:0]  r_rs1;
   logic [DW-1:0]  r_rs2;
   logic [OPW-1:0] r_type;

   logic           r_taken;
   logic           r_illegal;
   logic [DW-1:0]  r_target;

   logic           w_cond_taken;
   logic           w_cond_illegal;
   logic [DW-1:0]  w_tgt_taken;
   logic [DW-1:0]  w_tgt_fall;
   logic [DW-1:0]  w_tgt_sel;

   logic           w_in_fire;
   logic           w_redir_fire;
   logic           w_res_fire;

   br_cond #(
      .DW  (DW),
      .OPW (OPW)
   ) u_br_cond (
      .rs1     (r_rs1),
      .rs2     (r_rs2),
      .typ     (r_type),
      .taken   (w_cond_taken),
      .illegal (w_cond_illegal)
   );

   // Both targets wrap modulo 2^DW; the immediate is a word offset.
   assign w_tgt_taken = r_pc + {r_imm[DW-3:0], 2'b00};
   assign w_tgt_fall  = r_pc + DW'(4);
   assign w_tgt_sel   = w_cond_taken ? w_tgt_taken : w_tgt_fall;

   // Handshakes are gated by kill so an abort cycle never completes a transfer.
   assign w_in_fire    = (r_state == S_IDLE)  & in_valid    & ~kill;
   assign w_redir_fire = (r_state == S_REDIR) & redir_ready & ~kill;
   assign w_res_fire   = (r_state == S_DONE)  & res_ready   & ~kill;

   assign in_ready    = (r_state == S_IDLE);
   assign redir_valid = (r_state == S_REDIR);
   assign res_valid   = (r_state == S_DONE);
   assign flush       = w_redir_fire;
   assign redir_pc    = r_target;
   assign res_target  = r_target;
   assign res_taken   = r_taken;
   assign res_illegal = r_illegal;

   // Next-state selection; kill overrides every other transition.
   always_comb begin
      w_state_nxt = r_state;
      if (kill) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_in_fire)    w_state_nxt = S_EVAL;
            S_EVAL:  w_state_nxt = w_cond_taken ? S_REDIR : S_DONE;
            S_REDIR: if (w_redir_fire) w_state_nxt = S_DONE;
            S_DONE:  if (w_res_fire)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Operand capture on an accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc   <= '0;
         r_imm  <= '0;
         r_rs1  <= '0;
         r_rs2  <= '0;
         r_type <= '0;
      end else if (w_in_fire) begin
         r_pc   <= in_pc;
         r_imm  <= in_imm;
         r_rs1  <= in_rs1;
         r_rs2  <= in_rs2;
         r_type <= in_type;
      end
   end

   // Register the resolution at the end of the evaluate cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_taken   <= 1'b0;
         r_illegal <= 1'b0;
         r_target  <= '0;
      end else if ((r_state == S_EVAL) && !kill) begin
         r_taken   <= w_cond_taken;
         r_illegal <= w_cond_illegal;
         r_target  <= w_tgt_sel;
      end
   end

`ifdef BR_RESOLVE_STATS_EN
   logic [31:0] r_stat_total;
   logic [31:0] r_stat_taken;

   assign stat_total = r_stat_total;
   assign stat_taken = r_stat_taken;

   // Count accepted resolutions; counters wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_total <= '0;
         r_stat_taken <= '0;
      end else if (w_res_fire) begin
         r_stat_total <= r_stat_total + 32'd1;
         if (r_taken) r_stat_taken <= r_stat_taken + 32'd1;
      end
   end
`endif

endmodule
